bit_serializer: RTL and testbench

Parallel-to-serial transmitter that produces the data/enable bit stream consumed by the team's enabled D-flop capture cells and deserializers. It accepts a WIDTH-bit word over a valid/ready handshake, then shifts it out one bit per DIV clock cycles on SD. SEN strobes once per bit, in the bit's last cycle, so a downstream register clocked by CLK with EN=SEN captures each bit while SD is stable. It sits between a parallel producer and any serial sink clocked by the same CLK.

---
 rtl/bit_serializer_pkg.sv | 14 +
 rtl/bit_timer.sv | 31 +++
 rtl/bit_serializer.sv | 98 +++++++++
 tb/tb_bit_serializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer and its bit timer.
package bit_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } bit_ser_state_e;

   // Counter width for a 0..n-1 count, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period divider: counts 0..DIV-1 and flags the last cycle of each bit.
module bit_timer
   import bit_serializer_pkg::*;
#(
   parameter int unsigned DIV = 4
)(
   input  logic CLK,
   input  logic RST,
   input  logic CLR,
   output logic TICK
);

   localparam int unsigned   CW   = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign TICK = (count == LAST);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter: one WIDTH-bit word per handshake, one bit per DIV cycles,
// with a strobe in each bit's last cycle. Outputs are decoded from flops only.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIV       = 4,
   parameter bit          MSB_FIRST = 1'b1
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DIN,
   input  logic             DIN_VALID,
   output logic             DIN_READY,
   output logic             SD,
   output logic             SEN,
   output logic             SOF,
   output logic             EOF,
   output logic             BUSY
);

   localparam int unsigned   BW       = cnt_width(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   bit_ser_state_e   state;
   bit_ser_state_e   state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic             timer_tick;
   logic             timer_clr;
   logic             tick;
   logic             last_tick;
   logic             load;

   // Timer is held cleared while idle so every word starts from a fresh bit period.
   bit_timer #(
      .DIV (DIV)
   ) u_timer (
      .CLK  (CLK),
      .RST  (RST),
      .CLR  (timer_clr),
      .TICK (timer_tick)
   );

   assign tick      = (state == SHIFT) && timer_tick;
   assign last_tick = tick && (bit_cnt == LAST_BIT);
   assign DIN_READY = !RST && ((state == IDLE) || last_tick);
   assign load      = DIN_VALID && DIN_READY;
   assign timer_clr = load || (state == IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = SHIFT;
         SHIFT:   if (last_tick && !load) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the shift register is a plain register, not a memory, so it is reset to keep SD at 0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         shreg   <= DIN;
         bit_cnt <= '0;
      end else if (tick) begin
         shreg   <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
         bit_cnt <= last_tick ? '0 : bit_cnt + BW'(1);
      end
   end

   always_comb begin
      SD   = 1'b0;
      SEN  = 1'b0;
      SOF  = 1'b0;
      EOF  = 1'b0;
      BUSY = 1'b0;
      if (state == SHIFT) begin
         BUSY = 1'b1;
         SD   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
         SEN  = tick;
         SOF  = tick && (bit_cnt == '0);
         EOF  = last_tick;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: two serializers (DIV=4 MSB-first, DIV=1 LSB-first) against a bit-list model.
module tb_bit_serializer;

   typedef struct {
      logic   b;
      logic   sof;
      logic   eof;
      longint when;
   } ent_t;

   logic            CLK = 1'b0;
   logic            RST;
   logic [1:0][7:0] din;
   logic [1:0]      valid;
   logic [1:0]      ready;
   logic [1:0]      sd;
   logic [1:0]      sen;
   logic [1:0]      sof;
   logic [1:0]      eof;
   logic [1:0]      busy;

   int     errors = 0;
   int     checks = 0;
   longint cyc    = 0;
   bit     mon_en = 1'b0;
   ent_t   q[2][$];

   always #5 CLK = ~CLK;

   bit_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) u_dut (
      .CLK(CLK), .RST(RST), .DIN(din[0]), .DIN_VALID(valid[0]), .DIN_READY(ready[0]),
      .SD(sd[0]), .SEN(sen[0]), .SOF(sof[0]), .EOF(eof[0]), .BUSY(busy[0])
   );

   bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_fast (
      .CLK(CLK), .RST(RST), .DIN(din[1]), .DIN_VALID(valid[1]), .DIN_READY(ready[1]),
      .SD(sd[1]), .SEN(sen[1]), .SOF(sof[1]), .EOF(eof[1]), .BUSY(busy[1])
   );

   task automatic check(input string name, input int d, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0d expected %0d at cycle %0d", name, d, act, exp, cyc);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // A reset edge aborts any word in flight.
   always @(posedge CLK) begin
      if (RST === 1'b1) begin
         q[0].delete();
         q[1].delete();
      end
   end

   always @(negedge CLK) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            ent_t e;
            check("busy", d, 64'(busy[d]), 64'(q[d].size() != 0));
            if (q[d].size() != 0) check("sd", d, 64'(sd[d]), 64'(q[d][0].b));
            else                  check("sd_idle", d, 64'(sd[d]), 64'd0);
            if (sen[d] !== 1'b0) begin
               if (q[d].size() == 0) begin
                  check("sen_unexpected", d, 64'(sen[d]), 64'd0);
               end else begin
                  e = q[d].pop_front();
                  check("sof", d, 64'(sof[d]), 64'(e.sof));
                  check("eof", d, 64'(eof[d]), 64'(e.eof));
                  check("sen_cycle", d, 64'(cyc), 64'(e.when));
               end
            end else begin
               check("strobe_idle", d, 64'({sof[d], eof[d]}), 64'd0);
               if (q[d].size() != 0 && cyc >= q[d][0].when) begin
                  check("sen_missing", d, 64'(sen[d]), 64'd1);
                  void'(q[d].pop_front());
               end
            end
         end
      end
   end

   // Offers one word, waits for the handshake and queues its expected bit sequence.
   task automatic send(input int d, input logic [7:0] w, output longint e0);
      bit   hs     = 1'b0;
      int   budget = 0;
      ent_t e;
      e0 = 0;
      din[d]   = w;
      valid[d] = 1'b1;
      while (!hs && budget < 300) begin
         #1;
         hs = ready[d];
         @(posedge CLK);
         if (hs) begin
            e0 = cyc;
            for (int k = 0; k < 8; k++) begin
               e.b    = (d == 0) ? w[7-k] : w[k];
               e.sof  = (k == 0);
               e.eof  = (k == 7);
               e.when = e0 + (k + 1) * ((d == 0) ? 4 : 1);
               q[d].push_back(e);
            end
         end
         @(negedge CLK);
         budget++;
      end
      if (!hs) check("handshake_timeout", d, 64'(hs), 64'd1);
      valid[d] = 1'b0;
      din[d]   = 8'($urandom);
   endtask

   task automatic wait_idle();
      int budget = 0;
      while ((q[0].size() != 0 || q[1].size() != 0) && budget < 500) begin
         @(negedge CLK);
         budget++;
      end
      if (budget >= 500) check("drain_timeout", 0, 64'(q[0].size() + q[1].size()), 64'd0);
      @(negedge CLK);
   endtask

   initial begin
      longint t0;
      longint t1;
      RST   = 1'b1;
      valid = 2'b11;
      din   = {8'hFF, 8'hFF};

      // Reset held two cycles with DIN_VALID asserted.
      @(posedge CLK);
      mon_en = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         for (int d = 0; d < 2; d++) begin
            check("rst_ready", d, 64'(ready[d]), 64'd0);
            check("rst_outputs", d, 64'({sd[d], sen[d], sof[d], eof[d], busy[d]}), 64'd0);
         end
         if (c == 1) begin
            RST   = 1'b0;
            valid = 2'b00;
            #1;
            for (int d = 0; d < 2; d++) check("ready_after_rst", d, 64'(ready[d]), 64'd1);
         end
      end
      @(negedge CLK);

      // Single word, MSB first.
      send(0, 8'hA5, t0);
      wait_idle();

      // Streaming: second word accepted in the EOF cycle.
      send(0, 8'h3C, t0);
      send(0, 8'hC3, t1);
      check("stream_spacing", 0, 64'(t1 - t0), 64'd32);
      wait_idle();

      // Offer a word mid-transfer: must be refused until the EOF cycle.
      send(0, 8'h00, t0);
      repeat (12) @(negedge CLK);
      din[0]   = 8'hFF;
      valid[0] = 1'b1;
      #1;
      check("busy_ready", 0, 64'(ready[0]), 64'd0);
      send(0, 8'hFF, t1);
      check("busy_accept", 0, 64'(t1 - t0), 64'd32);
      wait_idle();

      // Reset right after bit 2's strobe, then a clean word.
      send(0, 8'h5A, t0);
      repeat (11) @(negedge CLK);
      RST = 1'b1;
      #1;
      check("midrst_ready", 0, 64'(ready[0]), 64'd0);
      @(negedge CLK);
      check("midrst_quiet", 0, 64'({sen[0], busy[0]}), 64'd0);
      @(negedge CLK);
      RST = 1'b0;
      send(0, 8'h81, t0);
      wait_idle();

      // Fastest rate, LSB first.
      send(1, 8'h01, t0);
      wait_idle();

      // Random traffic on both instances with random gaps.
      repeat (60) begin
         int d;
         d = int'($urandom_range(0, 1));
         repeat ($urandom_range(0, 2)) @(negedge CLK);
         send(d, 8'($urandom), t0);
      end
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
